// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Shares one DDRAM burst interface between two requesters (p0, p1) in the
// clk_sys domain. Ownership is held for a whole burst: a read stays owned
// until the last read beat returns, a write until its last beat is accepted.
//
// Configuration macro: DDR_ARB_FIXED_PRIO_EN
//   defined   : port 0 wins every tie (port 1 may starve).
//   undefined : round-robin; on a tie the port other than last_grant wins,
//               last_grant resets to 1 so port 0 wins the first tie.
//
// Ports
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   pN_rd / pN_wr               read request / write beat, held while waitReq=1
//   pN_addr, pN_burstLength     burst start address and beat count (0 => 1)
//   pN_mask, pN_din             write byte enables and data
//   pN_waitReq                  stall; always 1 for the port not owning the bus
//   pN_valid                    read beat valid for this port
//   pN_dout                     read data, broadcast of ddr_dout
//   ddr_*                       DDRAM burst master interface
//   dbg_state                   current FSM state for observation
//
// Handshake: a request (rd or wr) is taken on a rising edge where it is high
// and the matching waitReq is low; the requester keeps it and its attributes
// stable until then. ddr_rd/ddr_wr follow the same rule against ddr_waitReq.
module ddr_burst_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    p0_rd,
  input  logic                    p0_wr,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [BURST_WIDTH-1:0]  p0_burstLength,
  input  logic [DATA_WIDTH/8-1:0] p0_mask,
  input  logic [DATA_WIDTH-1:0]   p0_din,
  output logic                    p0_waitReq,
  output logic                    p0_valid,
  output logic [DATA_WIDTH-1:0]   p0_dout,
  input  logic                    p1_rd,
  input  logic                    p1_wr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [BURST_WIDTH-1:0]  p1_burstLength,
  input  logic [DATA_WIDTH/8-1:0] p1_mask,
  input  logic [DATA_WIDTH-1:0]   p1_din,
  output logic                    p1_waitReq,
  output logic                    p1_valid,
  output logic [DATA_WIDTH-1:0]   p1_dout,
  output logic                    ddr_rd,
  output logic                    ddr_wr,
  output logic [ADDR_WIDTH-1:0]   ddr_addr,
  output logic [BURST_WIDTH-1:0]  ddr_burstLength,
  output logic [DATA_WIDTH/8-1:0] ddr_mask,
  output logic [DATA_WIDTH-1:0]   ddr_din,
  input  logic [DATA_WIDTH-1:0]   ddr_dout,
  input  logic                    ddr_waitReq,
  input  logic                    ddr_valid,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_READ_CMD  = 3'd2,
    S_READ_DATA = 3'd3,
    S_WRITE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;

  logic                   req0, req1, grant;
  logic                   g_rd, g_wr;
  logic                   own_rd, own_wr;
  logic [BURST_WIDTH-1:0] own_burst, beats_init, beats_rem;
  logic                   own_wait, own_valid;

  assign req0 = p0_rd | p0_wr;
  assign req1 = p1_rd | p1_wr;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  assign g_rd = grant ? p1_rd : p0_rd;
  assign g_wr = grant ? p1_wr : p0_wr;

  // Everything towards DDR is taken from the registered owner; ddr_rd/ddr_wr
  // gate whether it means anything.
  assign own_rd          = owner_q ? p1_rd          : p0_rd;
  assign own_wr          = owner_q ? p1_wr          : p0_wr;
  assign own_burst       = owner_q ? p1_burstLength : p0_burstLength;
  assign ddr_addr        = owner_q ? p1_addr        : p0_addr;
  assign ddr_burstLength = own_burst;
  assign ddr_mask        = owner_q ? p1_mask        : p0_mask;
  assign ddr_din         = owner_q ? p1_din         : p0_din;

  // A zero-length burst still moves one beat.
  assign beats_init = (own_burst == '0) ? BURST_WIDTH'(1) : own_burst;
  // Write beats are loaded on the first accepted beat; beats_q is 0 until then.
  assign beats_rem  = (beats_q == '0) ? beats_init : beats_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beats_d      = beats_q;
    ddr_rd       = 1'b0;
    ddr_wr       = 1'b0;
    own_wait     = 1'b1;
    own_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) state_d = S_ARB;
      end
      S_ARB: begin
        owner_d = grant;
        if (g_rd) begin
          // rd wins over a simultaneous wr on the same port
          state_d      = S_READ_CMD;
          last_grant_d = grant;
        end else if (g_wr) begin
          state_d      = S_WRITE;
          last_grant_d = grant;
        end else begin
          // request withdrawn before the grant took effect
          state_d = S_IDLE;
        end
      end
      S_READ_CMD: begin
        ddr_rd = 1'b1;
        if (!ddr_waitReq) begin
          own_wait = 1'b0;
          beats_d  = beats_init;
          state_d  = S_READ_DATA;
        end
      end
      S_READ_DATA: begin
        if (ddr_valid) begin
          own_valid = 1'b1;
          if (beats_q <= BURST_WIDTH'(1)) begin
            beats_d = '0;
            state_d = S_IDLE;
          end else begin
            beats_d = beats_q - BURST_WIDTH'(1);
          end
        end
      end
      S_WRITE: begin
        ddr_wr   = own_wr;
        own_wait = ddr_waitReq;
        if (own_wr && !ddr_waitReq) begin
          if (beats_rem == BURST_WIDTH'(1)) begin
            beats_d = '0;
            state_d = S_IDLE;
          end else begin
            beats_d = beats_rem - BURST_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beats_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beats_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beats_q      <= beats_d;
    end
  end

  // own_rd is only informative: the read command is driven from the state.
  logic unused_own_rd;
  assign unused_own_rd = own_rd;

  assign p0_waitReq = owner_q ? 1'b1 : own_wait;
  assign p1_waitReq = owner_q ? own_wait : 1'b1;
  assign p0_valid   = ~owner_q & own_valid;
  assign p1_valid   = owner_q & own_valid;
  assign p0_dout    = ddr_dout;
  assign p1_dout    = ddr_dout;
  assign dbg_state  = state_q;

endmodule
